// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count_sequencer block.
// COUNT_SEQUENCER_VERIFY_EN (see count_sequencer.sv) adds the end-value check.
package count_seq_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  // Wrap count saturates here at the default width.
  localparam logic [WIDTH_DEFAULT-1:0] WRAPS_SAT = '1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StCount = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating incrementer with synchronous clear and enable; clear wins over enable.
module sat_counter
  import count_seq_pkg::*;
#(
  parameter int unsigned Width = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] One = Width'(1);
  localparam logic [Width-1:0] Max = '1;

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Max)) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_sequencer.sv
// Drives a parallel-load counter: load a start value, issue N increments, count wraps.
// Define COUNT_SEQUENCER_VERIFY_EN to check the final counter value against start+steps.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_steps,
  input  logic             hold,
  input  logic [WIDTH-1:0] counter_A,
  input  logic             counter_carry,
  output logic             load,
  output logic             increment,
  output logic [WIDTH-1:0] I,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] wraps,
  output logic             mismatch
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             accept;

  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    steps_d     = steps_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          start_d = cmd_start;
          steps_d = cmd_steps;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (steps_q == '0) begin
          state_d = StDone;
        end else begin
          remaining_d = steps_q;
          state_d     = StCount;
        end
      end
      StCount: begin
        if (!hold) begin
          remaining_d = remaining_q - One;
          if (remaining_q == One) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= StIdle;
      start_q     <= '0;
      steps_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      steps_q     <= steps_d;
      remaining_q <= remaining_d;
    end
  end

  // Ready is withheld while clear is asserted so nothing is offered during reset.
  assign cmd_ready = (state_q == StIdle) & ~clear;
  assign load      = (state_q == StLoad);
  assign increment = (state_q == StCount) & ~hold;
  assign I         = start_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  sat_counter #(
    .Width (WIDTH)
  ) u_wraps (
    .clk_i (clock),
    .rst_i (clear),
    .clr_i (accept),
    .en_i  (increment & counter_carry),
    .cnt_o (wraps)
  );

`ifdef COUNT_SEQUENCER_VERIFY_EN
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             mismatch_q, mismatch_d;

  always_comb begin
    expected_d = expected_q;
    mismatch_d = mismatch_q;
    if (accept) begin
      expected_d = cmd_start + cmd_steps;
      mismatch_d = 1'b0;
    end else if ((state_q == StDone) && (counter_A != expected_q)) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      expected_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_counter_a;
  assign unused_counter_a = ^counter_A;
  assign mismatch         = 1'b0;
`endif

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural counter closing the loop.
module tb_count_sequencer;

`ifdef COUNT_SEQUENCER_VERIFY_EN
  localparam int VerifyEn = 1;
`else
  localparam int VerifyEn = 0;
`endif

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_start = '0;
  logic [3:0] cmd_steps = '0;
  logic       hold = 1'b0;
  logic [3:0] counter_A = '0;
  logic       counter_carry;
  logic       load, increment, busy, done, mismatch;
  logic [3:0] I, wraps;
  logic [3:0] corrupt_mask = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  count_sequencer #(
    .WIDTH (4)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_start     (cmd_start),
    .cmd_steps     (cmd_steps),
    .hold          (hold),
    .counter_A     (counter_A),
    .counter_carry (counter_carry),
    .load          (load),
    .increment     (increment),
    .I             (I),
    .busy          (busy),
    .done          (done),
    .wraps         (wraps),
    .mismatch      (mismatch)
  );

  // Counter stage being driven; corrupt_mask lets a test load a wrong value.
  always @(posedge clock) begin
    if (load) counter_A <= I ^ corrupt_mask;
    else if (increment) counter_A <= counter_A + 4'd1;
  end
  assign counter_carry = increment & (counter_A == 4'hF);

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer a command and return just after the acceptance edge.
  task automatic issue(input logic [3:0] s, input logic [3:0] n, input bit keep_valid);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_start = s;
    cmd_steps = n;
    check_eq("ready_before_accept", int'(cmd_ready), 1);
    @(posedge clock);
    #1;
    if (!keep_valid) cmd_valid = 1'b0;
    cmd_start = ~s;
    cmd_steps = ~n;
  endtask

  // Cycle-by-cycle trace after acceptance until done (bounded).
  task automatic trace(input logic [3:0] exp_start, input int hold_at, input int hold_len,
                       output int done_cyc, output int loads, output int incs,
                       output int bad_i, output int a_done, output int w_done);
    int held;
    held     = 0;
    done_cyc = 0;
    loads    = 0;
    incs     = 0;
    bad_i    = 0;
    a_done   = -1;
    w_done   = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(posedge clock);
        #1;
      end
      if (incs == hold_at && held < hold_len) begin
        hold = 1'b1;
        held++;
      end else begin
        hold = 1'b0;
      end
      @(negedge clock);
      if (load) begin
        loads++;
        if (I != exp_start) bad_i++;
      end
      if (increment) incs++;
      if (done) begin
        done_cyc = c;
        a_done   = int'(counter_A);
        w_done   = int'(wraps);
        break;
      end
    end
    hold = 1'b0;
  endtask

  int dc, ld, ic, bi, ad, wd;
  bit saw_done;

  initial begin
    // Reset state
    #2;
    check_eq("rst_load", int'(load), 0);
    check_eq("rst_inc", int'(increment), 0);
    check_eq("rst_I", int'(I), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_wraps", int'(wraps), 0);
    check_eq("rst_mismatch", int'(mismatch), 0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check_eq("rst_ready", int'(cmd_ready), 1);

    // start=2 steps=5
    issue(4'd2, 4'd5, 1'b0);
    trace(4'd2, -1, 0, dc, ld, ic, bi, ad, wd);
    check_eq("t1_done_cyc", dc, 7);
    check_eq("t1_loads", ld, 1);
    check_eq("t1_incs", ic, 5);
    check_eq("t1_I", bi, 0);
    check_eq("t1_A", ad, 7);
    check_eq("t1_wraps", wd, 0);
    @(negedge clock);
    check_eq("t1_done_pulse", int'(done), 0);
    check_eq("t1_busy_after", int'(busy), 0);
    check_eq("t1_ready_after", int'(cmd_ready), 1);
    check_eq("t1_mismatch", int'(mismatch), 0);
    check_eq("t1_I_held", int'(I), 2);

    // start=14 steps=3: one wrap
    issue(4'd14, 4'd3, 1'b0);
    trace(4'd14, -1, 0, dc, ld, ic, bi, ad, wd);
    check_eq("t2_done_cyc", dc, 5);
    check_eq("t2_A", ad, 1);
    check_eq("t2_wraps", wd, 1);
    repeat (2) @(negedge clock);
    check_eq("t2_wraps_hold", int'(wraps), 1);

    // start=9 steps=0: load only
    issue(4'd9, 4'd0, 1'b0);
    trace(4'd9, -1, 0, dc, ld, ic, bi, ad, wd);
    check_eq("t3_done_cyc", dc, 2);
    check_eq("t3_loads", ld, 1);
    check_eq("t3_incs", ic, 0);
    check_eq("t3_A", ad, 9);
    check_eq("t3_wraps", wd, 0);

    // start=0 steps=8 with a 3-cycle hold after the 2nd increment
    issue(4'd0, 4'd8, 1'b0);
    trace(4'd0, 2, 3, dc, ld, ic, bi, ad, wd);
    check_eq("t4_done_cyc", dc, 13);
    check_eq("t4_incs", ic, 8);
    check_eq("t4_A", ad, 8);

    // clear during COUNT
    issue(4'd3, 4'd10, 1'b0);
    repeat (4) @(negedge clock);
    check_eq("t5_busy_mid", int'(busy), 1);
    clear = 1'b1;
    #1;
    check_eq("t5_clr_load", int'(load), 0);
    check_eq("t5_clr_inc", int'(increment), 0);
    check_eq("t5_clr_I", int'(I), 0);
    check_eq("t5_clr_busy", int'(busy), 0);
    check_eq("t5_clr_wraps", int'(wraps), 0);
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    clear = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    check_eq("t5_no_done", int'(saw_done), 0);
    check_eq("t5_ready", int'(cmd_ready), 1);
    issue(4'd1, 4'd1, 1'b0);
    trace(4'd1, -1, 0, dc, ld, ic, bi, ad, wd);
    check_eq("t5_done_cyc", dc, 3);
    check_eq("t5_A", ad, 2);

    // corrupted counter load: start=4 steps=1, counter ends at 6
    corrupt_mask = 4'd1;
    issue(4'd4, 4'd1, 1'b0);
    trace(4'd4, -1, 0, dc, ld, ic, bi, ad, wd);
    corrupt_mask = 4'd0;
    check_eq("t6_A", ad, 6);
    @(negedge clock);
    check_eq("t6_mismatch", int'(mismatch), VerifyEn);
    repeat (2) @(negedge clock);
    check_eq("t6_mismatch_hold", int'(mismatch), VerifyEn);

    // back-to-back with cmd_valid held: (5,2) then (15,1)
    issue(4'd5, 4'd2, 1'b1);
    cmd_start = 4'd15;
    cmd_steps = 4'd1;
    trace(4'd5, -1, 0, dc, ld, ic, bi, ad, wd);
    check_eq("t7a_done_cyc", dc, 4);
    check_eq("t7a_A", ad, 7);
    check_eq("t7a_wraps", wd, 0);
    @(negedge clock);
    check_eq("t7_gap_ready", int'(cmd_ready), 1);
    check_eq("t7a_mismatch", int'(mismatch), 0);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_start = 4'd0;
    trace(4'd15, -1, 0, dc, ld, ic, bi, ad, wd);
    check_eq("t7b_done_cyc", dc, 3);
    check_eq("t7b_I", bi, 0);
    check_eq("t7b_A", ad, 0);
    check_eq("t7b_wraps", wd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Upstream controller for the parallel-load counter stage.
- Accepts a command (start value, step count) over a valid/ready handshake.
- Drives the counter's load, I and increment inputs to load the start value, then issues exactly the requested number of increments.
- Counts counter carry-outs (wraps) and reports completion with a one-cycle done pulse.

Parameters:
WIDTH, 4, counter data width; applies to the start value, step count, I, A and the wrap count.

Ports:
clock  input  1  system clock; all state updates on rising edge
clear  input  1  asynchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command; high only in IDLE
cmd_start  input  WIDTH  value to parallel-load into the counter
cmd_steps  input  WIDTH  number of increments to issue; 0 = load only
hold  input  1  pause counting while high; affects COUNT only
counter_A  input  WIDTH  counter output A, fed back
counter_carry  input  1  counter output_carry, fed back
load  output  1  counter parallel-load enable
increment  output  1  counter increment enable
I  output  WIDTH  counter parallel-load data
busy  output  1  high in LOAD, COUNT and DONE
done  output  1  one-cycle completion pulse
wraps  output  WIDTH  carry-outs seen during the current or last command; saturates at all ones
mismatch  output  1  final A differs from expected (see Optional Feature)

Behaviour:
- Reset: clear high asynchronously forces IDLE.
  - load=0, increment=0, I=0, done=0, busy=0, wraps=0, mismatch=0.
  - Internal start, remaining and expected registers = 0.
  - cmd_ready=1 once clear is low.
  - clear mid-command abandons the command: no done pulse, all outputs return to reset values.
- Counter contract:
  - load has priority over increment.
  - A <= I on load; A <= A+1 mod 2^WIDTH on increment.
  - counter_carry is high when A is all ones and increment is high.
- FSM, one state per cycle unless stated:
  - IDLE: cmd_ready=1. On cmd_valid & cmd_ready, capture cmd_start and cmd_steps, clear wraps and mismatch, go to LOAD. cmd_valid without ready is ignored.
  - LOAD: load=1, I=captured start, increment=0.
    - steps==0: go to DONE.
    - Otherwise: remaining=steps, go to COUNT.
  - COUNT: increment = ~hold.
    - On each edge with increment=1: remaining decrements; if counter_carry=1, wraps increments, saturating at 2^WIDTH-1.
    - When remaining==1 at an edge with increment=1: go to DONE.
    - hold=1 freezes remaining, wraps and state indefinitely.
  - DONE: done=1, busy=1, cmd_ready=0, load=0, increment=0. Then go to IDLE.
- Latency without hold:
  - Acceptance edge is E0.
  - load is high in the cycle after E0.
  - increment is high for the next `steps` cycles.
  - done is high in cycle steps+2 after E0.
  - counter_A in the DONE cycle equals (start+steps) mod 2^WIDTH.
- Outputs held between commands:
  - wraps holds its value in IDLE until the next acceptance.
  - I holds the last start value outside LOAD.
- Back-to-back commands: with cmd_valid held high, the next command is accepted in the IDLE cycle right after DONE. Minimum gap is one IDLE cycle.
- hold in IDLE, LOAD or DONE has no effect.
- cmd_start and cmd_steps are sampled only at acceptance; later changes are ignored.

Optional Feature:
COUNT_SEQUENCER_VERIFY_EN
- Defined:
  - At acceptance, expected = (cmd_start+cmd_steps) mod 2^WIDTH is registered.
  - In DONE, counter_A is compared against expected.
  - mismatch is set to 1 on inequality, in the cycle after DONE, and holds until the next acceptance or clear.
- Undefined: mismatch is tied to constant 0 and no expected register exists.

Decomposition:
- Package count_seq_pkg holds:
  - state enum {IDLE, LOAD, COUNT, DONE} with a 2-bit encoding;
  - WIDTH default constant;
  - localparam for the saturation value.
- One natural sub-module: sat_counter, a WIDTH-bit saturating incrementer with synchronous clear and enable, used for wraps.
- FSM and datapath stay in count_sequencer.

Test Plan:
- start=2, steps=5, WIDTH=4, no hold -> load 1 cycle with I=2, increment 5 cycles, done in cycle 7 after acceptance, counter_A=7, wraps=0, mismatch=0.
- start=14, steps=3 -> counter_A=1 at done, wraps=1.
- start=9, steps=0 -> load 1 cycle, increment never high, done in cycle 2, counter_A=9, wraps=0.
- start=0, steps=8, hold high for 3 cycles after the 2nd increment -> increment low for those 3 cycles, done delayed by exactly 3 cycles, counter_A=8.
- clear pulsed during COUNT of start=3, steps=10 -> all outputs 0 immediately, no done pulse, cmd_ready=1 after release. A new command start=1, steps=1 then completes normally.
- cmd_valid held high with two commands (5,2) then (15,1) -> second accepted one IDLE cycle after the first done, giving counter_A=7 then 0 and wraps=0 then 1. With VERIFY_EN and the counter forced to a wrong value, mismatch=1.
